// File: rtl/offset_byte_key_extractor.sv
// Buffers the first header beats of each packet and extracts a byte-aligned key
// (offset/length instruction) once both header and instruction are present.
module offset_byte_key_extractor #(
    parameter int C_AXIS_DATA_WIDTH = 256,
    parameter int C_RAM_WIDTH       = 16,
    parameter int C_RAM_DEPTH_WIDTH = 5,
    parameter int C_KEY_WIDTH       = 128,
    parameter int HDR_BEATS         = 2
) (
    input  logic                           axis_clk,
    input  logic                           aresetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tlast,
    input  logic [C_RAM_WIDTH-1:0]         i_bram_off_byte,
    input  logic                           i_bram_off_byte_valid,
    input  logic [C_RAM_DEPTH_WIDTH-1:0]   i_bram_off_byte_addrb,
    output logic [C_KEY_WIDTH-1:0]         o_key,
    output logic                           o_key_valid,
    output logic                           o_key_err,
    output logic [C_RAM_DEPTH_WIDTH-1:0]   o_key_addr,
    output logic                           o_instr_drop,
    output logic                           o_pkt_drop
);

    localparam int BEAT_BYTES = C_AXIS_DATA_WIDTH / 8;
    localparam int HDR_W      = C_AXIS_DATA_WIDTH * HDR_BEATS;
    localparam int HDR_BYTES  = BEAT_BYTES * HDR_BEATS;
    localparam int KEY_BYTES  = C_KEY_WIDTH / 8;
    localparam int IDX_W      = (HDR_BEATS > 2) ? $clog2(HDR_BEATS) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CAPT = 3'd1,
        S_REST = 3'd2,
        S_WAIT = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [HDR_W-1:0]               r_buf;
    logic [IDX_W-1:0]               r_beat_idx;
    logic                           r_hdr_done;
    logic                           r_pend;
    logic                           r_key_done;
    logic [C_RAM_WIDTH-1:0]         r_instr;
    logic [C_RAM_DEPTH_WIDTH-1:0]   r_addr;

    logic [C_AXIS_DATA_WIDTH-1:0]   w_beat;
    logic                           w_cap_first;
    logic                           w_cap_next;
    logic                           w_hdr_set;
    logic                           w_beat_drop;
    logic                           w_fire;
    logic                           w_legal;
    logic [7:0]                     w_off;
    logic [7:0]                     w_len;
    logic [8:0]                     w_end;
    logic [C_KEY_WIDTH-1:0]         w_window;
    logic [C_KEY_WIDTH-1:0]         w_key;

    // The stream is snooped: there is no tready, every beat with tvalid high is
    // consumed in the cycle it is presented.
    always_comb begin
        w_beat = '0;
        for (int k = 0; k < BEAT_BYTES; k++) begin
            if (s_axis_tkeep[k]) begin
                w_beat[8*k +: 8] = s_axis_tdata[8*k +: 8];
            end
        end
    end

    assign w_fire = r_hdr_done && r_pend && !r_key_done;

    always_comb begin
        w_state_nxt = r_state;
        w_cap_first = 1'b0;
        w_cap_next  = 1'b0;
        w_hdr_set   = 1'b0;
        w_beat_drop = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (s_axis_tvalid) begin
                    w_cap_first = 1'b1;
                    if (s_axis_tlast) begin
                        w_hdr_set   = 1'b1;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt = S_CAPT;
                    end
                end
            end
            S_CAPT: begin
                if (s_axis_tvalid) begin
                    w_cap_next = 1'b1;
                    if (s_axis_tlast) begin
                        w_hdr_set   = 1'b1;
                        w_state_nxt = S_WAIT;
                    end else if (r_beat_idx == IDX_W'(HDR_BEATS - 1)) begin
                        w_hdr_set   = 1'b1;
                        w_state_nxt = S_REST;
                    end
                end
            end
            S_REST: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_state_nxt = (r_key_done || w_fire) ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (s_axis_tvalid) begin
                    w_beat_drop = 1'b1;
                    if (!s_axis_tlast) begin
                        w_state_nxt = S_DROP;
                    end else if (w_fire) begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_fire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DROP: begin
                if (s_axis_tvalid) begin
                    w_beat_drop = 1'b1;
                    if (s_axis_tlast) begin
                        w_state_nxt = (r_key_done || w_fire) ? S_IDLE : S_WAIT;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= S_IDLE;
            r_buf      <= '0;
            r_beat_idx <= '0;
            r_hdr_done <= 1'b0;
            r_key_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cap_first) begin
                r_buf      <= HDR_W'(w_beat);
                r_beat_idx <= IDX_W'(1);
            end else if (w_cap_next) begin
                for (int b = 1; b < HDR_BEATS; b++) begin
                    if (r_beat_idx == IDX_W'(b)) begin
                        r_buf[b*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH] <= w_beat;
                    end
                end
                r_beat_idx <= r_beat_idx + 1'b1;
            end
            // Returning to IDLE starts a fresh packet: both flags drop together.
            if (w_state_nxt == S_IDLE) begin
                r_hdr_done <= 1'b0;
                r_key_done <= 1'b0;
            end else begin
                if (w_hdr_set) begin
                    r_hdr_done <= 1'b1;
                end
                if (w_fire) begin
                    r_key_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_pend  <= 1'b0;
            r_instr <= '0;
            r_addr  <= '0;
        end else begin
            if (i_bram_off_byte_valid) begin
                r_pend  <= 1'b1;
                r_instr <= i_bram_off_byte;
                r_addr  <= i_bram_off_byte_addrb;
            end else if (w_fire) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign w_off    = r_instr[C_RAM_WIDTH-1 -: 8];
    assign w_len    = r_instr[7:0];
    assign w_end    = {1'b0, w_off} + {1'b0, w_len};
    assign w_legal  = (w_len != 8'd0) && (w_len <= 8'(KEY_BYTES)) && (w_end <= 9'(HDR_BYTES));
    assign w_window = C_KEY_WIDTH'(r_buf >> {w_off, 3'b000});

    // First extracted byte lands in the most significant key byte.
    always_comb begin
        w_key = '0;
        for (int j = 0; j < KEY_BYTES; j++) begin
            if (8'(j) < w_len) begin
                w_key[C_KEY_WIDTH-1-8*j -: 8] = w_window[8*j +: 8];
            end
        end
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            o_key        <= '0;
            o_key_valid  <= 1'b0;
            o_key_err    <= 1'b0;
            o_key_addr   <= '0;
            o_instr_drop <= 1'b0;
            o_pkt_drop   <= 1'b0;
        end else begin
            o_key_valid  <= w_fire;
            o_key_err    <= w_fire && !w_legal;
            o_instr_drop <= i_bram_off_byte_valid && r_pend && !w_fire;
            o_pkt_drop   <= w_beat_drop;
            if (w_fire) begin
                o_key      <= w_legal ? w_key : '0;
                o_key_addr <= r_addr;
            end
        end
    end

endmodule

// File: doc/offset_byte_key_extractor.md
# offset_byte_key_extractor

Downstream consumer of the offset-byte BRAM stage: takes the per-packet 16-bit offset/length instruction (`o_bram_off_byte`/`_valid`/`_addrb` of the config stage) and the data-path AXI-Stream packet. It buffers the first two beats of the header and extracts a byte-aligned field of up to 16 bytes as a left-aligned 128-bit key for the deparser/action stages. Instruction and header may arrive in either order; the key is emitted once both are present.

## Interface
Parameters:
- C_AXIS_DATA_WIDTH, 256, packet beat width (32 bytes)
- C_RAM_WIDTH, 16, instruction width: [15:8] byte offset, [7:0] byte length
- C_RAM_DEPTH_WIDTH, 5, instruction address width, carried through untouched
- C_KEY_WIDTH, 128, key width (max 16 bytes)
- HDR_BEATS, 2, header beats buffered (64 bytes)

Ports (one clock, `axis_clk`; reset `aresetn` is asynchronous, active-low):
- axis_clk  in  1  clock
- aresetn  in  1  async active-low reset
- s_axis_tdata  in  256  packet data, byte k at [8k+:8]
- s_axis_tkeep  in  32  byte enables
- s_axis_tvalid  in  1  beat valid (no backpressure; snooped)
- s_axis_tlast  in  1  last beat
- i_bram_off_byte  in  16  instruction
- i_bram_off_byte_valid  in  1  instruction strobe, one cycle
- i_bram_off_byte_addrb  in  5  instruction address tag
- o_key  out  128  extracted field, first byte at [127:120], zero-padded
- o_key_valid  out  1  one-cycle pulse
- o_key_err  out  1  qualifies o_key_valid: illegal instruction
- o_key_addr  out  5  addrb tag of the consumed instruction
- o_instr_drop  out  1  pulse: pending instruction overwritten
- o_pkt_drop  out  1  pulse: beat of a discarded packet

## Operation
- Header buffer: 64 bytes, cleared at each packet start. Beat b byte k is stored at buffer byte 32b+k if tkeep[k], else 0.
- Instruction register: latched on i_bram_off_byte_valid and pend set. A new strobe while pend=1 overwrites it and pulses o_instr_drop.
- Flags: hdr_done (beat 1 captured, or tlast on beat 0), pend, key_done.
- FSM states:
  - IDLE: on beat, capture beat 0; tlast -> WAIT, else -> CAPT.
  - CAPT: on beat, capture beat 1; tlast -> WAIT, else -> REST.
  - REST: discard beats; on tlast -> IDLE if key_done or extracting that cycle, else -> WAIT.
  - WAIT (packet ended, key pending): any beat pulses o_pkt_drop; if not tlast -> DROP.
  - DROP: discard and pulse o_pkt_drop each beat; on tlast -> WAIT, or IDLE if key_done.
- WAIT -> IDLE when extraction fires. Re-entering IDLE clears hdr_done and key_done.
- Extraction fires in any cycle with hdr_done && pend && !key_done: clears pend, sets key_done.
  - off = instr[15:8], len = instr[7:0].
  - Legal iff 1 <= len <= 16 and off+len <= 64 (9-bit sum, no wrap).
  - Legal: o_key byte j (at [127-8j -:8]) = buffer[off+j] for j < len, 0 otherwise.
  - Illegal: o_key = 0, o_key_err = 1.
  - o_key_addr = latched addrb in both cases.
- Bytes beyond the packet end read as 0 and are not an error.

## Timing
- Reset values: o_key 0, o_key_valid 0, o_key_err 0, o_key_addr 0, o_instr_drop 0, o_pkt_drop 0. FSM in IDLE, all flags and the buffer cleared.
- Reset asserted mid-packet discards all state. After release, the block waits in IDLE; the next beat seen is treated as beat 0.
- Latency: if E is the clock edge at which the later of {hdr_done, instruction} is registered, outputs update at edge E+1. o_key_valid and o_key_err are high for exactly one cycle.
- Same-cycle instruction strobe and header-completing beat: both registered at E, key at E+1.
- o_key and o_key_addr hold their value until the next extraction.
- An instruction strobe in the extraction cycle latches a new pending instruction and does not pulse o_instr_drop.
- o_instr_drop and o_pkt_drop are registered, one cycle after the causing input.

## Test plan
- Beat0 bytes 0x00..0x1F, beat1 0x20..0x3F, tlast on beat1; instr 0x0C02 two cycles later -> o_key[127:112]=0x0C0D, rest 0, err=0, one-cycle valid.
- Same packet, instr 0x1C08 strobed with beat1 -> key bytes 0x1C..0x23 (straddling beats), valid one edge after beat1.
- Instr 0x3A08 (58+8=66) and, separately, 0x0500 (len 0) -> o_key_valid=1, o_key_err=1, o_key=0.
- Instr 0x0004 with addrb 5'h13 before any packet, then a 1-beat packet with tkeep=0x0000000F, bytes AA BB CC DD -> key 0xAABBCCDD000..., o_key_addr=5'h13.
- Two strobes before the header -> o_instr_drop pulses once; the second instruction is used. 4-beat packet with no instruction, followed by a 2-beat packet -> o_pkt_drop pulses twice; a later instruction extracts from the first packet.
- aresetn low during beat1 of a 3-beat packet -> all outputs 0. A fresh packet plus instruction after release extracts correctly.
